addsub_arbiter: RTL
===================

# addsub_arbiter

Round-robin arbiter and sequencer that shares one saturating 16-bit add/subtract datapath between two requesters, typically the execute-stage ALU and the address/PC-offset path. It accepts one operation per cycle from a valid/ready request port, computes the saturated sum or difference, and holds the result in a one-entry output register with a valid/ready response handshake. It also keeps per-requester grant counters for performance debug.

## Interface
- `CNT_W`, 16, width of each grant counter.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0_valid` input 1: requester 0 has an operation.
- `req0_a`, `req0_b` input 16 each: requester 0 operands, two's complement.
- `req0_sub` input 1: requester 0 operation select, 1 = a - b, 0 = a + b.
- `req0_ready` output 1: requester 0 operation accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_sub`, `req1_ready`: same as requester 0, for requester 1.
- `resp_valid` output 1: result register holds a result.
- `resp_ready` input 1: consumer takes the result this cycle.
- `resp_id` output 1: requester that owns the result.
- `resp_data` output 16: saturated result.
- `resp_ovfl` output 1: saturation occurred.
- `grant_cnt0`, `grant_cnt1` output CNT_W: accepted-operation counts per requester.

## Operation
- **Output register states:**
  - EMPTY when `resp_valid`=0.
  - FULL when `resp_valid`=1.
- **Grant enable:** `can_accept = !resp_valid | resp_ready`. There is no grant when `can_accept` is 0.
- **Arbitration:**
  - The priority pointer `prio` has reset value 0.
  - With only one requester valid, that requester is granted.
  - With both valid, requester `prio` is granted.
  - After every grant, `prio` is set to the non-granted requester's index, so the last winner loses the next tie.
  - `prio` is unchanged in cycles with no grant.
- **Ready outputs:** `reqN_ready` is combinational and asserted only for the granted requester. At most one `ready` is high per cycle. `ready` never asserts without the matching `valid`.
- **Arithmetic on a grant:**
  - Effective operand: `b_eff` = `sub` ? ~b : b, carry-in = `sub`.
  - Raw result: raw = a + b_eff + cin, mod 2^16.
  - Overflow: ovfl = (a[15] == b_eff[15]) & (raw[15] != a[15]).
  - Saturated result: if ovfl, the result is 16'h7FFF when a[15]=0 and 16'h8000 when a[15]=1. Otherwise the result is raw.
- **On a grant:** `resp_data`, `resp_ovfl` and `resp_id` are loaded, `resp_valid` is set to 1, and the granted requester's grant counter increments. Counters wrap modulo 2^CNT_W.
- **Drain without grant:** when `resp_ready` is high with `resp_valid` high and no grant occurs, `resp_valid` clears to 0. The data fields hold their last value.
- **Simultaneous drain and grant:** the register reloads and `resp_valid` stays 1, giving one result per cycle throughput.
- **Holding while FULL:** while FULL with `resp_ready`=0, all `resp_*` outputs hold stable and both `ready` outputs are 0.
- **Reset values:**
  - 0 for `resp_valid`, `resp_id`, `resp_ovfl`, `prio`, `grant_cnt0` and `grant_cnt1`.
  - 16'h0000 for `resp_data`.
  - Reset overrides any concurrent grant or drain. An in-flight result is discarded and no counter increments in the reset cycle.

## Timing
- Latency is 1 cycle: a grant in cycle N gives `resp_valid`=1 with its result in cycle N+1.
- Sustained throughput is 1 op/cycle while `resp_ready` is held high.
- Handshake rules for requesters:
  - Operands must be stable while `valid`=1 and `ready`=0.
  - A requester must not drop `valid` before it sees `ready`.
- The `ready` outputs depend combinationally on `valid`, `resp_valid`, `resp_ready` and `prio`. There is no combinational path from operands to `ready`.
- The adder path is combinational from the granted operands to the result register, within one cycle.

## Test plan
- **Reset:** assert `rst` for 2 cycles with both requests valid -> all outputs at their reset values, both `ready`=0 during reset, `grant_cnt0`=`grant_cnt1`=0.
- **Single add:** req0 presents a=16'h1234, b=16'h0111, sub=0 -> `req0_ready`=1 that cycle. Next cycle `resp_valid`=1, `resp_data`=16'h1345, `resp_id`=0, `resp_ovfl`=0, `grant_cnt0`=1.
- **Saturation:**
  - req1 presents a=16'h7FFF, b=16'h0001, add -> 16'h7FFF with ovfl=1.
  - req1 presents a=16'h8000, b=16'h0001, sub -> 16'h8000 with ovfl=1.
  - req1 presents a=16'h8000, b=16'h8000, sub -> 16'h0000 with ovfl=0.
- **Round robin:** both requesters valid continuously for 6 cycles with `resp_ready`=1 -> grants go 0,1,0,1,0,1, one result per cycle, `grant_cnt0`=`grant_cnt1`=3.
- **Backpressure:** hold `resp_ready`=0 for 4 cycles after the first result -> `resp_*` outputs stable and both `ready`=0. Raise `resp_ready` with both requesters valid -> the result drains and the next grant loads in the same cycle, with `resp_valid` staying 1.
- **Reset mid-operation and counter wrap:**
  - Assert `rst` while FULL -> `resp_valid`=0 on the next cycle.
  - With CNT_W=4, make 17 grants to req0 -> `grant_cnt0`=1.

Source files
------------

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin shared saturating 16-bit add/sub unit with one-entry result register
module addsub_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  input  logic             req0_sub,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  input  logic             req1_sub,
  output logic             req1_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [15:0]      resp_data,
  output logic             resp_ovfl,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t      state;
  state_t      state_nxt;
  logic        prio;
  logic        can_accept;
  logic        grant0;
  logic        grant1;
  logic        grant;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_sub;
  logic [15:0] b_eff;
  logic [15:0] raw;
  logic        ovfl;
  logic [15:0] sat;

  assign resp_valid = (state == FULL);
  assign grant      = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Arbitrate: grant only when the result slot is free or draining; prio breaks ties.
  // Reset masks grants so neither requester sees ready while the block is held.
  always_comb begin
    can_accept = !resp_valid || resp_ready;
    grant0     = 1'b0;
    grant1     = 1'b0;
    if (!rst && can_accept) begin
      if (req0_valid && (!req1_valid || !prio)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  // Shared datapath: select the granted operands, add or subtract, then clamp on overflow.
  always_comb begin
    op_a   = grant1 ? req1_a   : req0_a;
    op_b   = grant1 ? req1_b   : req0_b;
    op_sub = grant1 ? req1_sub : req0_sub;
    b_eff  = op_sub ? ~op_b : op_b;
    raw    = op_a + b_eff + {15'd0, op_sub};
    ovfl   = (op_a[15] == b_eff[15]) && (raw[15] != op_a[15]);
    sat    = raw;
    if (ovfl) begin
      sat = op_a[15] ? 16'h8000 : 16'h7FFF;
    end
  end

  // Result slot next state: a grant always fills, a drain without grant empties.
  always_comb begin
    state_nxt = state;
    if (grant) begin
      state_nxt = FULL;
    end else if (resp_valid && resp_ready) begin
      state_nxt = EMPTY;
    end
  end

  // Result slot state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Load result fields, rotate priority to the loser and count grants; data holds on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_data  <= 16'h0000;
      resp_ovfl  <= 1'b0;
      resp_id    <= 1'b0;
      prio       <= 1'b0;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (grant) begin
      resp_data <= sat;
      resp_ovfl <= ovfl;
      resp_id   <= grant1;
      prio      <= grant0;
      if (grant0) begin
        grant_cnt0 <= grant_cnt0 + CNT_ONE;
      end else begin
        grant_cnt1 <= grant_cnt1 + CNT_ONE;
      end
    end
  end

endmodule
